iob_reset_manager: RTL and testbench
====================================

IOB_RESET_MANAGER -- requirements
Module: iob_reset_manager

Interface
REQ-001 SHALL have parameter N_RST, default 3: number of reset output channels, range 1..8.
REQ-002 SHALL have parameter DURATION, default 10: HOLD cycles with all resets asserted, ≥1.
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive channel releases, ≥1.
REQ-004 SHALL have parameter WAIT_CALIB, default 1: 1 = gate ready_o on calib_done_i; 0 = ignore calib_done_i.
REQ-005 SHALL have parameter CAL_TIMEOUT, default 1000: WAIT_CAL cycle limit, 0 = no limit.
REQ-006 SHALL have parameter CNT_W, default 16: internal counter width; DURATION, STAGGER and CAL_TIMEOUT SHALL each fit in CNT_W bits.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port arstn_i, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port cke_i, input, 1 bit: clock enable.
REQ-010 SHALL have port locked_i, input, 1 bit: PLL lock, asynchronous.
REQ-011 SHALL have port calib_done_i, input, 1 bit: memory-controller calibration done, asynchronous.
REQ-012 SHALL have port sw_rst_i, input, 1 bit: synchronous single-cycle software reset request.
REQ-013 SHALL have port rst_o, output, N_RST bits: active-high per-channel resets, registered.
REQ-014 SHALL have port ready_o, output, 1 bit: all channels released and calibration satisfied.
REQ-015 SHALL have port calib_err_o, output, 1 bit: sticky flag, calibration timeout occurred.
REQ-016 SHALL have port state_o, output, 3 bits: current FSM state.

Function
REQ-017 locked_i and calib_done_i SHALL each pass through a 2-flop synchronizer (lock_s, cal_s); cal_s is then valid 2 edges after its input changes.
REQ-018 FSM states and encodings SHALL be WAIT_LOCK=0, HOLD=1, RELEASE=2, WAIT_CAL=3, RUN=4; state_o SHALL equal the state register.
REQ-019 WAIT_LOCK: rst_o SHALL be all ones; when lock_s=1 the FSM SHALL go to HOLD with cnt=0.
REQ-020 HOLD: rst_o SHALL stay all ones and cnt SHALL increment; at the edge with cnt==DURATION-1 the FSM SHALL go to RELEASE with rst_o[0]<=0, idx=1, cnt=0.
REQ-021 RELEASE: cnt SHALL increment; at cnt==STAGGER-1, rst_o[idx] SHALL clear, idx SHALL increment and cnt SHALL reset to 0.
REQ-022 RELEASE SHALL go to WAIT_CAL on the edge that clears rst_o[N_RST-1]; with N_RST=1 it SHALL go to WAIT_CAL on the next edge.
REQ-023 Release timing: locked_i sampled high at edge E0 SHALL place rst_o[k] low after edge E0+2+DURATION+k*STAGGER.
REQ-024 Released channels SHALL stay low; rst_o SHALL never reassert individually.
REQ-025 WAIT_CAL: go to RUN with ready_o<=1 on the next edge when WAIT_CALIB=0 or cal_s=1.
REQ-026 WAIT_CAL timeout: if CAL_TIMEOUT≠0 and the WAIT_CAL cycle count reaches CAL_TIMEOUT, calib_err_o<=1 and the FSM SHALL go to RUN with ready_o<=1.
REQ-027 Once in RUN, a later fall of cal_s SHALL not affect outputs.
REQ-028 sw_rst_i=1 in RELEASE, WAIT_CAL or RUN SHALL set rst_o all ones, ready_o=0 and cnt=0, and go to HOLD on the next edge.
REQ-029 sw_rst_i SHALL be ignored in WAIT_LOCK and HOLD.
REQ-030 lock_s=0 in any state except WAIT_LOCK SHALL set rst_o all ones, ready_o=0 and go to WAIT_LOCK on the next edge.
REQ-031 Lock loss SHALL take priority over sw_rst_i and cke_i.
REQ-032 cke_i=0 SHALL freeze state, cnt, idx and outputs, except for the lock-loss action (REQ-030).
REQ-033 calib_err_o SHALL clear only on arstn_i; sw_rst_i SHALL not clear it.

Reset
REQ-034 arstn_i=0 SHALL immediately force: rst_o all ones, ready_o=0, calib_err_o=0, state=WAIT_LOCK, cnt=0, idx=0, synchronizers=0.
REQ-035 Deassertion of arstn_i mid-sequence SHALL restart from WAIT_LOCK.

Verification
REQ-036 Defaults, cke_i=1, locked_i rises at E0, calib_done_i=1 -> rst_o[0] falls after E12, rst_o[1] after E16, rst_o[2] after E20, ready_o=1 after E21, state_o=4.
REQ-037 Defaults, calib_done_i held 0 -> state_o=3 for 1000 cycles, then calib_err_o=1, ready_o=1; after a later sw_rst_i, calib_err_o remains 1.
REQ-038 In RUN, pulse sw_rst_i one cycle -> rst_o=3'b111 and ready_o=0 next edge, then full re-release with rst_o[0] low DURATION cycles after HOLD entry.
REQ-039 locked_i drops during RELEASE after rst_o[0] cleared -> rst_o=3'b111 two to three edges later, state_o=0; lock restore repeats REQ-036 timing.
REQ-040 cke_i=0 for 5 cycles mid-HOLD -> every release shifts by exactly 5 cycles; arstn_i pulsed low in RUN -> outputs at reset values immediately.

Source files
------------

// File: rtl/iob_reset_manager.sv
// Power-on reset sequencer: waits for PLL lock, holds every reset channel, releases
// channels one at a time, then optionally waits for memory calibration before ready_o.
module iob_reset_manager #(
    parameter int N_RST       = 3,
    parameter int DURATION    = 10,
    parameter int STAGGER     = 4,
    parameter int WAIT_CALIB  = 1,
    parameter int CAL_TIMEOUT = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             cke_i,
    input  logic             locked_i,
    input  logic             calib_done_i,
    input  logic             sw_rst_i,
    output logic [N_RST-1:0] rst_o,
    output logic             ready_o,
    output logic             calib_err_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        RELEASE   = 3'd2,
        WAIT_CAL  = 3'd3,
        RUN       = 3'd4
    } state_t;

    // idx must be able to hold N_RST itself (one past the last channel)
    localparam int IDX_W = $clog2(N_RST + 1);

    localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DURATION - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((CAL_TIMEOUT > 0) ? CAL_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RST - 1);

    logic [1:0]       lock_ff;
    logic [1:0]       cal_ff;
    logic             lock_s;
    logic             cal_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_RST-1:0] rst_q, rst_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lock_ff <= 2'b00;
            cal_ff  <= 2'b00;
        end else begin
            lock_ff <= {lock_ff[0], locked_i};
            cal_ff  <= {cal_ff[0], calib_done_i};
        end
    end

    assign lock_s = lock_ff[1];
    assign cal_s  = cal_ff[1];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        err_d   = err_q;

        // Lock loss acts even while the clock enable is low
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else if (cke_i) begin
            if (sw_rst_i && (state_q == RELEASE || state_q == WAIT_CAL || state_q == RUN)) begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end else begin
                case (state_q)
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end
                    end
                    HOLD: begin
                        if (cnt_q == DUR_LAST) begin
                            state_d  = RELEASE;
                            rst_d[0] = 1'b0;
                            idx_d    = IDX_W'(1);
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (N_RST == 1) begin
                            state_d = WAIT_CAL;
                            cnt_d   = '0;
                        end else if (cnt_q == STG_LAST) begin
                            for (int i = 0; i < N_RST; i++) begin
                                if (IDX_W'(i) == idx_q) rst_d[i] = 1'b0;
                            end
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = '0;
                            if (idx_q == IDX_LAST) state_d = WAIT_CAL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    WAIT_CAL: begin
                        if (WAIT_CALIB == 0 || cal_s) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else if (CAL_TIMEOUT != 0 && cnt_q == CAL_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    RUN: begin
                    end
                    default: begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                        ready_d = 1'b0;
                    end
                endcase
            end
        end
    end

    assign rst_o       = rst_q;
    assign ready_o     = ready_q;
    assign calib_err_o = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_iob_reset_manager.sv
// Bench for iob_reset_manager: every change of {state_o, rst_o, ready_o, calib_err_o}
// is matched against a queue of (cycle, value) entries computed by hand from stimulus timing.
module tb_iob_reset_manager;

    localparam int W = 40;
    localparam logic [2:0] ST_WL  = 3'd0;
    localparam logic [2:0] ST_HLD = 3'd1;
    localparam logic [2:0] ST_REL = 3'd2;
    localparam logic [2:0] ST_WC  = 3'd3;
    localparam logic [2:0] ST_RUN = 3'd4;

    logic       clk;
    logic       arstn;
    logic       cke;
    logic       locked;
    logic       calib_done;
    logic       sw_rst;
    logic [2:0] rst_o;
    logic       ready_o;
    logic       calib_err_o;
    logic [2:0] state_o;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] last_obs = 8'hxx;

    iob_reset_manager dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .cke_i       (cke),
        .locked_i    (locked),
        .calib_done_i(calib_done),
        .sw_rst_i    (sw_rst),
        .rst_o       (rst_o),
        .ready_o     (ready_o),
        .calib_err_o (calib_err_o),
        .state_o     (state_o)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: each visible output change pops one expected entry
    always @(negedge clk) begin
        logic [7:0]   obs;
        logic [W-1:0] e;
        obs = {state_o, rst_o, ready_o, calib_err_o};
        if (obs !== last_obs) begin
            last_obs = obs;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e[W-1:8] != 32'(cyc) || e[7:0] !== obs) begin
                    miscompares++;
                    $display("FAIL out_change got cyc=%0d {st,rst,rdy,err}=%b required cyc=%0d %b",
                             cyc, obs, e[W-1:8], e[7:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic expect_at(input int c, input logic [2:0] st, input logic [2:0] r,
                             input logic rd, input logic er);
        exp_q.push_back({32'(c), st, r, rd, er});
    endtask

    // h = cycle of HOLD entry, sh = extra frozen cycles inside HOLD
    task automatic expect_release(input int h, input int sh, input logic er);
        expect_at(h,           ST_HLD, 3'b111, 1'b0, er);
        expect_at(h + sh + 10, ST_REL, 3'b110, 1'b0, er);
        expect_at(h + sh + 14, ST_REL, 3'b100, 1'b0, er);
        expect_at(h + sh + 18, ST_WC,  3'b000, 1'b0, er);
        expect_at(h + sh + 19, ST_RUN, 3'b000, 1'b1, er);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int s;
        int k;
        arstn      = 1'b0;
        cke        = 1'b1;
        locked     = 1'b0;
        calib_done = 1'b1;
        sw_rst     = 1'b0;
        expect_at(1, ST_WL, 3'b111, 1'b0, 1'b0);

        // basic power-up: lock sampled at E0=5 -> HOLD at 7, releases at 17/21/25, RUN at 26
        wait_until(2);
        arstn = 1'b1;
        wait_until(4);
        locked = 1'b1;
        expect_release(7, 0, 1'b0);
        wait_until(29);

        // software reset from RUN
        s = cyc + 1;
        sw_rst = 1'b1;
        expect_release(s, 0, 1'b0);
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(s + 22);

        // lock loss after rst_o[0] released, then lock restored
        s = cyc + 1;
        sw_rst = 1'b1;
        expect_at(s,      ST_HLD, 3'b111, 1'b0, 1'b0);
        expect_at(s + 10, ST_REL, 3'b110, 1'b0, 1'b0);
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(s + 11);
        locked = 1'b0;
        expect_at(s + 14, ST_WL, 3'b111, 1'b0, 1'b0);
        wait_until(s + 16);
        locked = 1'b1;
        expect_release(s + 19, 0, 1'b0);
        wait_until(s + 19 + 22);

        // clock enable low for 5 edges inside HOLD
        s = cyc + 1;
        sw_rst = 1'b1;
        expect_release(s, 5, 1'b0);
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(s + 3);
        cke = 1'b0;
        wait_until(s + 8);
        cke = 1'b1;
        wait_until(s + 27);

        // calibration falls in RUN (no effect), then times out after a software reset
        calib_done = 1'b0;
        wait_until(cyc + 10);
        s = cyc + 1;
        sw_rst = 1'b1;
        expect_at(s,        ST_HLD, 3'b111, 1'b0, 1'b0);
        expect_at(s + 10,   ST_REL, 3'b110, 1'b0, 1'b0);
        expect_at(s + 14,   ST_REL, 3'b100, 1'b0, 1'b0);
        expect_at(s + 18,   ST_WC,  3'b000, 1'b0, 1'b0);
        expect_at(s + 1018, ST_RUN, 3'b000, 1'b1, 1'b1);
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(s + 1021);

        // software reset keeps the sticky calibration error
        s = cyc + 1;
        sw_rst = 1'b1;
        calib_done = 1'b1;
        expect_release(s, 0, 1'b1);
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(s + 22);

        // async reset in RUN, restart with lock still high; sw_rst in HOLD ignored
        @(posedge clk);
        #1;
        k = cyc;
        arstn = 1'b0;
        expect_at(k, ST_WL, 3'b111, 1'b0, 1'b0);
        wait_until(k + 2);
        arstn = 1'b1;
        expect_release(k + 5, 0, 1'b0);
        wait_until(k + 7);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        wait_until(k + 5 + 22);

        // final report
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares += exp_q.size();
            $display("FAIL leftover_expected got=%0d entries pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
